// File: rtl/fifo_uart_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter. Bytes from the flash read path
// are queued and shifted out LSB first on uart_tx. Push and pop events are
// exported as one-cycle trigger pulses.
//
// Ports:
//   CLKA         system clock, rising edge
//   rst_n        asynchronous active-low reset
//   wr_en        push request
//   wr_data      byte to push
//   clr_ovf      synchronous clear of the sticky overflow flag
//   full         occupancy == FIFO_DEPTH
//   empty        occupancy == 0
//   count        occupancy, 0..FIFO_DEPTH
//   overflow     sticky: a push was dropped while full
//   uart_tx      serial output, idle high
//   tx_busy      transmitter not idle
//   fifo_trig_wr one-cycle pulse per accepted push
//   fifo_trig_re one-cycle pulse per pop
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 174,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic              CLKA,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              uart_tx,
  output logic              tx_busy,
  output logic              fifo_trig_wr,
  output logic              fifo_trig_re
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]        mem [FIFO_DEPTH];

  state_t            state,    state_nxt;
  logic [BAUD_W-1:0] baud,     baud_nxt;
  logic [2:0]        bit_idx,  bit_idx_nxt;
  logic [7:0]        shift,    shift_nxt;
  logic              tx_nxt;
  logic [ADDR_W-1:0] wr_ptr,   wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr,   rd_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              overflow_nxt;

  logic              bit_end;
  logic              pop;
  logic              push;
  logic              drop;

  // Pop from IDLE, or on the final stop-bit cycle for gapless frames.
  assign bit_end = (baud == BAUD_LAST);
  assign pop     = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign push    = wr_en && (!full || pop);
  assign drop    = wr_en && full && !pop;

  // Storage has no reset: contents are meaningless once pointers clear.
  always_ff @(posedge CLKA) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Transmitter next-state and line value.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    tx_nxt      = uart_tx;

    case (state)
      S_IDLE: begin
        baud_nxt = '0;
      end
      S_START: begin
        if (bit_end) begin
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_DATA;
          tx_nxt      = shift[0];
        end else begin
          baud_nxt = baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {1'b0, shift[7:1]};
            tx_nxt      = shift[1];
          end
        end else begin
          baud_nxt = baud + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = S_IDLE;
          tx_nxt    = 1'b1;
        end else begin
          baud_nxt = baud + BAUD_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        baud_nxt  = '0;
        tx_nxt    = 1'b1;
      end
    endcase

    // A pop always starts a new frame, overriding the IDLE/STOP exits.
    if (pop) begin
      state_nxt = S_START;
      baud_nxt  = '0;
      shift_nxt = mem[rd_ptr];
      tx_nxt    = 1'b0;
    end
  end

  // FIFO bookkeeping.
  always_comb begin
    wr_ptr_nxt   = push ? wr_ptr + ADDR_W'(1) : wr_ptr;
    rd_ptr_nxt   = pop  ? rd_ptr + ADDR_W'(1) : rd_ptr;
    count_nxt    = count;
    overflow_nxt = overflow;

    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overflow_nxt = 1'b1;
    end else if (clr_ovf) begin
      overflow_nxt = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLKA or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      baud         <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      uart_tx      <= 1'b1;
      tx_busy      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      overflow     <= 1'b0;
      fifo_trig_wr <= 1'b0;
      fifo_trig_re <= 1'b0;
    end else begin
      state        <= state_nxt;
      baud         <= baud_nxt;
      bit_idx      <= bit_idx_nxt;
      shift        <= shift_nxt;
      uart_tx      <= tx_nxt;
      tx_busy      <= (state_nxt != S_IDLE);
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= (count_nxt == CNT_FULL);
      empty        <= (count_nxt == '0);
      overflow     <= overflow_nxt;
      fifo_trig_wr <= push;
      fifo_trig_re <= pop;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-and-frame-timer model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_fifo_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned FRAME = 10 * CPB;

  logic          CLKA = 1'b0;
  logic          rst_n;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_ovf = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          uart_tx;
  logic          tx_busy;
  logic          fifo_trig_wr;
  logic          fifo_trig_re;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_W      (AW)
  ) dut (
    .CLKA        (CLKA),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .clr_ovf     (clr_ovf),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .uart_tx     (uart_tx),
    .tx_busy     (tx_busy),
    .fifo_trig_wr(fifo_trig_wr),
    .fifo_trig_re(fifo_trig_re)
  );

  always #5 CLKA = ~CLKA;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];
  logic [7:0] m_popped[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_ovf    = 1'b0;
  bit         m_twr    = 1'b0;
  bit         m_tre    = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic model_step();
    bit pop, push, full_pre, frame_done;
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      m_twr    = 1'b0;
      m_tre    = 1'b0;
    end else begin
      frame_done = m_active && (m_pos == FRAME - 1);
      pop        = (m_q.size() > 0) && (!m_active || frame_done);
      full_pre   = (m_q.size() == DEPTH);
      push       = wr_en && (!full_pre || pop);
      if (wr_en && full_pre && !pop) m_ovf = 1'b1;
      else if (clr_ovf)              m_ovf = 1'b0;
      if (m_active) begin
        m_pos++;
        if (frame_done) m_active = 1'b0;
      end
      if (pop) begin
        m_byte = m_q.pop_front();
        m_popped.push_back(m_byte);
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (push) m_q.push_back(wr_data);
      m_twr = push;
      m_tre = pop;
    end
  endtask

  initial forever begin
    @(posedge CLKA or negedge rst_n);
    model_step();
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge CLKA);
    check("uart_tx",  uart_tx,  m_active ? frame_bit(m_byte, m_pos / CPB) : 1'b1);
    check("tx_busy",  tx_busy,  m_active);
    check("count",    count,    m_q.size());
    check("empty",    empty,    m_q.size() == 0);
    check("full",     full,     m_q.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    check("trig_wr",  fifo_trig_wr, m_twr);
    check("trig_re",  fifo_trig_re, m_tre);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLKA);
    #1;
  endtask

  task automatic settle();
    @(negedge CLKA);
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_pos(input int p, input string what);
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (m_active && m_pos == p) hit = 1'b1;
      else tick();
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout %s: got no frame position %0d expected within 400 cycles", what, p);
    end
  endtask

  task automatic wait_drain(input string what);
    bit hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (!m_active && m_q.size() == 0) hit = 1'b1;
      else tick();
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout %s: got busy expected drained within 1000 cycles", what);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  logic [9:0] a5_bits  = 10'b1101001010;
  logic [7:0] exp_pop[12] = '{8'hA5, 8'h00, 8'hFF, 8'h55, 8'h11, 8'h22,
                              8'h33, 8'h44, 8'h55, 8'h3C, 8'hF0, 8'h81};
  int peak;
  int busy_cycles;

  initial begin
    // 1. reset
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    settle();
    check("rst uart_tx", uart_tx, 1);
    check("rst empty",   empty,   1);
    check("rst count",   count,   0);
    check("rst tx_busy", tx_busy, 0);
    check("rst trig_wr", fifo_trig_wr, 0);
    check("rst trig_re", fifo_trig_re, 0);

    // 2. single frame 0xA5
    tick();
    push(8'hA5);
    settle();
    check("a5 trig_wr", fifo_trig_wr, 1);
    check("a5 empty",   empty,   0);
    check("a5 tx idle", uart_tx, 1);
    tick();
    settle();
    check("a5 trig_re", fifo_trig_re, 1);
    check("a5 count",   count,   0);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("a5 bit%0d", k), uart_tx, a5_bits[k]);
      repeat (CPB) begin tick(); settle(); end
    end
    check("a5 end busy",  tx_busy, 0);
    check("a5 end empty", empty,   1);
    check("a5 end line",  uart_tx, 1);

    // 3. back-to-back 0x00, 0xFF, 0x55
    tick();
    peak = 0;
    busy_cycles = 0;
    wr_en = 1'b1;
    for (int i = 0; i < 3 + 130; i++) begin
      if (i == 0) wr_data = 8'h00;
      if (i == 1) wr_data = 8'hFF;
      if (i == 2) wr_data = 8'h55;
      tick();
      if (i == 2) wr_en = 1'b0;
      settle();
      if (int'(count) > peak) peak = int'(count);
      if (tx_busy) busy_cycles++;
    end
    check("b2b peak count",  peak, 2);
    check("b2b busy cycles", busy_cycles, 3 * FRAME);
    check("b2b end empty",   empty, 1);

    // 4. overflow while a frame is in progress
    tick();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    settle();
    check("ovf count full", count, 4);
    check("ovf full",       full,  1);
    check("ovf pre",        overflow, 0);
    push(8'h77);
    settle();
    check("ovf set",      overflow, 1);
    check("ovf count",    count,    4);
    check("ovf no wr",    fifo_trig_wr, 0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    settle();
    check("ovf cleared",  overflow, 0);

    // 5. push landing on the stop-end pop while full
    wait_pos(FRAME - 1, "stop end");
    push(8'h3C);
    settle();
    check("simul count",   count, 4);
    check("simul full",    full,  1);
    check("simul trig_wr", fifo_trig_wr, 1);
    check("simul trig_re", fifo_trig_re, 1);
    check("simul ovf",     overflow, 0);
    wait_drain("drain after simul");
    settle();
    check("simul end busy", tx_busy, 0);

    // 6. reset during data bit 3
    tick();
    push(8'hF0);
    push(8'h12);
    wait_pos(17, "data bit 3");
    settle();
    check("mid line low", uart_tx, 0);
    check("mid count",    count,   1);
    #2 rst_n = 1'b0;
    #1;
    check("async tx",    uart_tx, 1);
    check("async count", count,   0);
    check("async busy",  tx_busy, 0);
    #9 rst_n = 1'b1;
    tick();
    push(8'h81);
    wait_drain("drain 0x81");
    settle();
    check("post rst busy", tx_busy, 0);

    // Model pop history pinned to the hand-derived byte order.
    check("popped size", m_popped.size(), 12);
    for (int i = 0; i < 12 && i < m_popped.size(); i++) begin
      check($sformatf("popped[%0d]", i), m_popped[i], exp_pop[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Byte FIFO plus 8N1 UART transmitter. It sits downstream of the SPI memory read path: bytes read from the external flash are pushed in, and the block serialises them onto UART_TX towards the host PC. Push and pop events are exported as single-cycle trigger pulses for the FIFO_TRIG_* test pins. One clock domain (CLKA, 20 MHz system clock).

Parameters:
CLKS_PER_BIT, 174, CLKA cycles per UART bit (20 MHz / 115200 baud, rounded); legal range ≥ 2
FIFO_DEPTH, 16, FIFO entries; must be a power of 2
ADDR_W, 4, log2(FIFO_DEPTH)

Ports:
CLKA  in  1  system clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  push request from the upstream memory read path
wr_data  in  8  byte to push
clr_ovf  in  1  synchronous clear of overflow
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
count  out  ADDR_W+1  current occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky flag: a push was dropped
uart_tx  out  1  serial line; idle high
tx_busy  out  1  high whenever the FSM is not in IDLE
fifo_trig_wr  out  1  one-cycle pulse per accepted push
fifo_trig_re  out  1  one-cycle pulse per pop

Behaviour:
- Reset (asynchronous, rst_n low):
  - uart_tx=1; tx_busy=0; count=0; empty=1; full=0; overflow=0; both trigger outputs 0.
  - Read/write pointers cleared; FSM goes to IDLE.
  - Reset mid-frame aborts the frame immediately. uart_tx goes high with no clock edge required. FIFO contents are discarded.
- FIFO:
  - Circular buffer. Pointers are ADDR_W bits and wrap from FIFO_DEPTH-1 to 0.
  - Push is accepted when wr_en && (!full || pop in the same cycle).
  - Accepted push: store wr_data at wr_ptr, increment wr_ptr, pulse fifo_trig_wr.
  - wr_en while full with no pop in that cycle: data dropped, pointers and count unchanged, overflow set to 1.
  - overflow clears only on clr_ovf or reset. If clr_ovf and a drop happen in the same cycle, set wins.
  - Simultaneous push and pop: count unchanged; both trigger pulses asserted.
  - full, empty and count are registered and consistent with each other in every cycle.
- Transmitter FSM (IDLE, START, DATA, STOP):
  - IDLE: if !empty, pop. Load shift_reg with mem[rd_ptr], increment rd_ptr, pulse fifo_trig_re, go to START. uart_tx stays 1 in the pop cycle.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. bit_idx runs 0..7.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. On the last stop cycle:
    - if !empty, pop and go straight to START (back-to-back, no extra idle bit);
    - else go to IDLE.
  - Baud counter runs 0..CLKS_PER_BIT-1, reloads at each bit boundary, and is held at 0 in IDLE.
  - uart_tx is driven from a register, so it carries no glitches.
- Latency:
  - Push into an empty FIFO while the FSM is IDLE, accepted at edge N:
    - empty falls after edge N;
    - pop happens at edge N+1;
    - uart_tx falls after edge N+1.
  - Frame length: exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames: gap 0.
- FSM state is not affected by wr_en or overflow.

Test Plan:
(Simulation uses CLKS_PER_BIT=4 and FIFO_DEPTH=4 unless stated otherwise.)
1. Reset: rst_n pulsed low for 10 ns, then high.
   -> uart_tx=1, empty=1, count=0, tx_busy=0, no trigger pulses.
2. Single frame: push 0xA5 once.
   -> one fifo_trig_wr pulse, then fifo_trig_re 1 cycle later.
   -> uart_tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
   -> tx_busy falls and empty=1 at the end.
3. Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles.
   -> three contiguous 40-cycle frames with no idle between them.
   -> count peaks at 2 (the first byte is popped at once), then returns to 0.
4. Overflow: fill the FIFO while a frame is in progress, then push 0x77 once more with no pop in that cycle.
   -> overflow=1, count=4, 0x77 never appears on the line.
   -> pulse clr_ovf -> overflow=0.
5. Full with simultaneous pop: hold full=1 and time a push 0x3C to land on the STOP-end pop cycle.
   -> push accepted, count stays 4, both trigger pulses seen.
   -> 0x3C transmitted last.
6. Reset mid-frame: assert rst_n during DATA bit 3.
   -> uart_tx=1 immediately (asynchronous), count=0.
   -> after release, a fresh push of 0x81 transmits cleanly.
